// File: rtl/init_sequencer_if.sv
// Table-initialisation bus from init_sequencer to the BTB, BHT and register file.
interface init_sequencer_if #(
   parameter int unsigned BTB_AW = 8,
   parameter int unsigned BTB_DW = 40,
   parameter int unsigned BHT_AW = 8,
   parameter int unsigned REG_AW = 5
);
   logic [BTB_AW-1:0] btb_addr;
   logic [BTB_DW-1:0] btb_init;
   logic              btb_we;
   logic [BHT_AW-1:0] bht_addr;
   logic [1:0]        bht_init;
   logic              bht_we;
   logic [REG_AW-1:0] reg_addr;
   logic [31:0]       reg_init;
   logic              reg_we;

   modport master (
      output btb_addr, btb_init, btb_we,
      output bht_addr, bht_init, bht_we,
      output reg_addr, reg_init, reg_we
   );

   modport slave (
      input btb_addr, btb_init, btb_we,
      input bht_addr, bht_init, bht_we,
      input reg_addr, reg_init, reg_we
   );
endinterface

// File: rtl/init_sequencer.sv
// Power-up/re-init controller: clears BTB, BHT and register file in turn, then
// holds the CPU in reset until a start request releases it.
module init_sequencer #(
   parameter int unsigned BTB_AW   = 8,
   parameter int unsigned BTB_DW   = 40,
   parameter int unsigned BHT_AW   = 8,
   parameter logic [1:0]  BHT_INIT = 2'b01,
   parameter int unsigned REG_AW   = 5,
   parameter int unsigned SP_IDX   = 2,
   parameter logic [31:0] SP_VALUE = 32'h0000_3FFC
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init_req,
   input  logic              start_req,
   init_sequencer_if.master  bus,
   output logic              busy,
   output logic              init_done,
   output logic              cpu_rst
);

   localparam int unsigned IW0 = (BTB_AW > BHT_AW) ? BTB_AW : BHT_AW;
   localparam int unsigned IW  = (IW0 > REG_AW) ? IW0 : REG_AW;
   localparam logic [IW-1:0] BTB_LAST = IW'((2 ** BTB_AW) - 1);
   localparam logic [IW-1:0] BHT_LAST = IW'((2 ** BHT_AW) - 1);
   localparam logic [IW-1:0] REG_LAST = IW'((2 ** REG_AW) - 1);
   localparam logic [IW-1:0] SP_AT    = IW'(SP_IDX);

   typedef enum logic [2:0] {
      S_IDLE, S_BTB, S_BHT, S_REG, S_DONE, S_RUN
   } state_t;

   state_t        state, state_n;
   logic [IW-1:0] idx, idx_n;
   logic          init_prev, start_prev;
   logic          init_edge, start_edge;

   logic [BTB_AW-1:0] btb_addr_n;
   logic [BTB_DW-1:0] btb_init_n;
   logic              btb_we_n;
   logic [BHT_AW-1:0] bht_addr_n;
   logic [1:0]        bht_init_n;
   logic              bht_we_n;
   logic [REG_AW-1:0] reg_addr_n;
   logic [31:0]       reg_init_n;
   logic              reg_we_n;
   logic              busy_n, init_done_n, cpu_rst_n;

   assign init_edge  = init_req & ~init_prev;
   assign start_edge = start_req & ~start_prev;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      case (state)
         S_IDLE: if (init_edge) begin state_n = S_BTB; idx_n = '0; end
         S_BTB: begin
            if (idx == BTB_LAST) begin state_n = S_BHT; idx_n = '0; end
            else idx_n = idx + IW'(1);
         end
         S_BHT: begin
            if (idx == BHT_LAST) begin state_n = S_REG; idx_n = '0; end
            else idx_n = idx + IW'(1);
         end
         S_REG: begin
            if (idx == REG_LAST) begin state_n = S_DONE; idx_n = '0; end
            else idx_n = idx + IW'(1);
         end
         S_DONE: begin
            if (init_edge) begin state_n = S_BTB; idx_n = '0; end
            else if (start_edge) state_n = S_RUN;
         end
         S_RUN: if (init_edge) begin state_n = S_BTB; idx_n = '0; end
         default: begin state_n = S_IDLE; idx_n = '0; end
      endcase
   end

   // Outputs are decoded from the next state so they land in flops alongside it.
   always_comb begin
      btb_addr_n  = '0;
      btb_init_n  = '0;
      btb_we_n    = 1'b0;
      bht_addr_n  = '0;
      bht_init_n  = '0;
      bht_we_n    = 1'b0;
      reg_addr_n  = '0;
      reg_init_n  = '0;
      reg_we_n    = 1'b0;
      busy_n      = 1'b0;
      init_done_n = 1'b0;
      cpu_rst_n   = 1'b1;
      case (state_n)
         S_BTB: begin
            btb_we_n   = 1'b1;
            btb_addr_n = idx_n[BTB_AW-1:0];
            busy_n     = 1'b1;
         end
         S_BHT: begin
            bht_we_n   = 1'b1;
            bht_addr_n = idx_n[BHT_AW-1:0];
            bht_init_n = BHT_INIT;
            busy_n     = 1'b1;
         end
         S_REG: begin
            reg_we_n   = 1'b1;
            reg_addr_n = idx_n[REG_AW-1:0];
            reg_init_n = (idx_n == SP_AT) ? SP_VALUE : '0;
            busy_n     = 1'b1;
         end
         S_DONE: init_done_n = 1'b1;
         S_RUN: begin
            init_done_n = 1'b1;
            cpu_rst_n   = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= S_IDLE;
         idx          <= '0;
         init_prev    <= 1'b0;
         start_prev   <= 1'b0;
         bus.btb_addr <= '0;
         bus.btb_init <= '0;
         bus.btb_we   <= 1'b0;
         bus.bht_addr <= '0;
         bus.bht_init <= '0;
         bus.bht_we   <= 1'b0;
         bus.reg_addr <= '0;
         bus.reg_init <= '0;
         bus.reg_we   <= 1'b0;
         busy         <= 1'b0;
         init_done    <= 1'b0;
         cpu_rst      <= 1'b1;
      end else begin
         state        <= state_n;
         idx          <= idx_n;
         init_prev    <= init_req;
         start_prev   <= start_req;
         bus.btb_addr <= btb_addr_n;
         bus.btb_init <= btb_init_n;
         bus.btb_we   <= btb_we_n;
         bus.bht_addr <= bht_addr_n;
         bus.bht_init <= bht_init_n;
         bus.bht_we   <= bht_we_n;
         bus.reg_addr <= reg_addr_n;
         bus.reg_init <= reg_init_n;
         bus.reg_we   <= reg_we_n;
         busy         <= busy_n;
         init_done    <= init_done_n;
         cpu_rst      <= cpu_rst_n;
      end
   end

endmodule

// File: tb/tb_init_sequencer.sv
// Directed bench for init_sequencer: full walks, start/re-init handshakes,
// ignored edges while busy, and reset mid-sequence.
module tb_init_sequencer;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic init_req = 1'b0;
   logic start_req = 1'b0;
   logic busy, init_done, cpu_rst;

   int unsigned tests = 0;
   int unsigned fails = 0;

   init_sequencer_if #(.BTB_AW(8), .BTB_DW(40), .BHT_AW(8), .REG_AW(5)) bus ();

   init_sequencer #(
      .BTB_AW(8), .BTB_DW(40), .BHT_AW(8), .BHT_INIT(2'b01),
      .REG_AW(5), .SP_IDX(2), .SP_VALUE(32'h0000_3FFC)
   ) dut (
      .clk(clk), .rst(rst), .init_req(init_req), .start_req(start_req),
      .bus(bus), .busy(busy), .init_done(init_done), .cpu_rst(cpu_rst)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic check_idle_bus(input string tag);
      check({tag, "_we"}, {bus.btb_we, bus.bht_we, bus.reg_we}, 3'b000);
      check({tag, "_addr"}, {bus.btb_addr, bus.bht_addr, bus.reg_addr}, 21'h0);
      check({tag, "_data"}, {bus.btb_init, bus.bht_init, bus.reg_init}, 74'h0);
   endtask

   // Drives an init_req edge and checks all 544 busy cycles plus the DONE state.
   task automatic run_sequence(input bit toggle);
      logic [2:0]  exp_we;
      logic [7:0]  exp_btb_a, exp_bht_a;
      logic [4:0]  exp_reg_a;
      logic [1:0]  exp_bht_d;
      logic [31:0] exp_reg_d;
      init_req = 1'b1;
      for (int c = 0; c < 544; c++) begin
         @(negedge clk);
         exp_btb_a = '0; exp_bht_a = '0; exp_reg_a = '0;
         exp_bht_d = '0; exp_reg_d = '0;
         if (c < 256) begin
            exp_we = 3'b100; exp_btb_a = 8'(c);
         end else if (c < 512) begin
            exp_we = 3'b010; exp_bht_a = 8'(c - 256); exp_bht_d = 2'b01;
         end else begin
            exp_we = 3'b001; exp_reg_a = 5'(c - 512);
            exp_reg_d = (c - 512 == 2) ? 32'h0000_3FFC : 32'h0;
         end
         check($sformatf("we[%0d]", c), {bus.btb_we, bus.bht_we, bus.reg_we}, exp_we);
         check($sformatf("btb_addr[%0d]", c), bus.btb_addr, exp_btb_a);
         check($sformatf("btb_init[%0d]", c), bus.btb_init, 40'h0);
         check($sformatf("bht_addr[%0d]", c), bus.bht_addr, exp_bht_a);
         check($sformatf("bht_init[%0d]", c), bus.bht_init, exp_bht_d);
         check($sformatf("reg_addr[%0d]", c), bus.reg_addr, exp_reg_a);
         check($sformatf("reg_init[%0d]", c), bus.reg_init, exp_reg_d);
         check($sformatf("busy_done_rst[%0d]", c), {busy, init_done, cpu_rst}, 3'b101);
         init_req = 1'b0;
         if (toggle && c >= 300 && c < 400) begin
            init_req  = c[0];
            start_req = ~c[0];
         end else begin
            start_req = 1'b0;
         end
      end
      @(negedge clk);
      check("done_ctl", {busy, init_done, cpu_rst}, 3'b011);
      check_idle_bus("done");
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_ctl", {busy, init_done, cpu_rst}, 3'b001);
      check_idle_bus("rst");
      rst = 1'b0;
      @(negedge clk);
      check("idle_ctl", {busy, init_done, cpu_rst}, 3'b001);

      // start_req before any init is ignored
      start_req = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_start_ignored", {busy, init_done, cpu_rst}, 3'b001);
      start_req = 1'b0;
      @(negedge clk);

      run_sequence(1'b0);
      repeat (3) @(negedge clk);
      check("done_hold", {busy, init_done, cpu_rst}, 3'b011);

      start_req = 1'b1;
      @(negedge clk);
      check("run_release", {busy, init_done, cpu_rst}, 3'b010);
      start_req = 1'b0;
      repeat (2) @(negedge clk);
      check("run_hold", {busy, init_done, cpu_rst}, 3'b010);
      check_idle_bus("run");

      // re-init from RUN with edge toggling during the BHT phase
      run_sequence(1'b1);
      repeat (4) @(negedge clk);
      check("reinit_no_release", {busy, init_done, cpu_rst}, 3'b011);

      // reset at BTB index 100, then restart with init_req already high
      init_req = 1'b1;
      for (int c = 0; c <= 100; c++) begin
         @(negedge clk);
         init_req = 1'b0;
      end
      check("mid_btb_addr", {bus.btb_we, bus.btb_addr}, {1'b1, 8'd100});
      rst = 1'b1;
      init_req = 1'b1;
      @(negedge clk);
      check("midrst_ctl", {busy, init_done, cpu_rst}, 3'b001);
      check_idle_bus("midrst");
      rst = 1'b0;
      @(negedge clk);
      check("restart_we", {bus.btb_we, bus.bht_we, bus.reg_we}, 3'b100);
      check("restart_addr", bus.btb_addr, 8'd0);
      check("restart_ctl", {busy, init_done, cpu_rst}, 3'b101);
      @(negedge clk);
      check("restart_addr1", bus.btb_addr, 8'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/init_sequencer.md
Name: init_sequencer

Overview:
- Power-up/re-init controller for the pipeline CPU.
- Walks every BTB entry, then every BHT entry, then every register-file entry, driving address/data/write-enable on each table's init bus.
- Holds the CPU in reset until init completes and a start request arrives.
- Sits between the FPGA switches and TOPCPU; replaces the free-running init stimulus with a handshaked sequence.

Parameters:
- BTB_AW, 8, BTB address width (depth 2^BTB_AW)
- BTB_DW, 40, BTB entry width (tag+target+valid)
- BHT_AW, 8, BHT address width (depth 2^BHT_AW)
- BHT_INIT, 2'b01, BHT reset counter value (weakly not-taken)
- REG_AW, 5, register-file address width (depth 2^REG_AW)
- SP_IDX, 2, register index loaded with SP_VALUE
- SP_VALUE, 32'h0000_3FFC, initial stack pointer

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- init_req  in  1  init switch level, pre-synchronized; rising edge requests init
- start_req  in  1  start switch level, pre-synchronized; rising edge releases CPU
- btb_addr  out  BTB_AW  BTB init address
- btb_init  out  BTB_DW  BTB init data
- btb_we  out  1  BTB init write enable
- bht_addr  out  BHT_AW  BHT init address
- bht_init  out  2  BHT init data
- bht_we  out  1  BHT init write enable
- reg_addr  out  REG_AW  register-file init address
- reg_init  out  32  register-file init data
- reg_we  out  1  register-file init write enable
- busy  out  1  init sequence in progress
- init_done  out  1  all tables initialized since last reset/init
- cpu_rst  out  1  reset to CPU core, active-high

Behaviour:
- Reset (rst=1 at clk edge):
  - State goes to IDLE; index counter goes to 0.
  - All addr/data/we outputs, busy and init_done go to 0; cpu_rst goes to 1.
  - Edge-detect registers go to 0, so a level already high on the first post-reset cycle counts as an edge.
- Edge detect: edge = level & ~prev; prev is registered every cycle.
- States: IDLE, BTB, BHT, REG, DONE, RUN.
- IDLE:
  - init_req edge -> BTB with idx=0 and busy=1.
  - start_req edge is ignored.
- BTB:
  - btb_we=1, btb_addr=idx, btb_init=0 (invalid entry).
  - idx increments each cycle.
  - At idx=2^BTB_AW-1: write that entry, idx wraps to 0, go to BHT.
  - Exactly 2^BTB_AW write cycles.
- BHT: same walk with bht_we=1 and bht_init=BHT_INIT; 2^BHT_AW cycles, then REG.
- REG:
  - reg_we=1, reg_addr=idx.
  - reg_init=SP_VALUE when idx==SP_IDX, else 0.
  - 2^REG_AW cycles, then DONE.
- Timing and exclusivity:
  - Outputs are registered. The write on the cycle of a state's last index is the final one.
  - Exactly one *_we is high per busy cycle.
  - No gap cycles between phases.
  - Total busy = 256+256+32 = 544 cycles with defaults.
- DONE:
  - busy=0, init_done=1, cpu_rst=1, all we=0, addresses held at 0.
  - start_req edge -> RUN; cpu_rst drops on the next clock.
  - init_req edge -> BTB (re-init) and init_done=0.
- RUN:
  - cpu_rst=0, init_done=1.
  - init_req edge -> BTB with cpu_rst=1 and init_done=0 on the same clock, so the CPU never runs on partially written tables.
  - start_req edge is ignored.
- During BTB/BHT/REG: init_req and start_req edges are ignored (not queued); prev still tracks.
- Simultaneous init_req and start_req edges in DONE: init wins.
- Simultaneous edges in RUN: init wins.
- rst mid-sequence:
  - Abort immediately to the reset values.
  - Partially written tables are not cleaned; the next init_req edge restarts from BTB idx 0.
- Whenever the corresponding *_we=0, the addr/data outputs are 0.

Test Plan:
- Reset, then init_req 0->1 -> busy=1 one cycle later; btb_we high 256 cycles with btb_addr 0..255, btb_init=0; then bht_we 256 cycles with bht_init=2'b01; then reg_we 32 cycles; init_done=1 and busy=0 at cycle 545.
- During REG phase -> reg_init=32'h0000_3FFC exactly when reg_addr=2, and 0 for every other address.
- start_req pulse before init (IDLE) -> cpu_rst stays 1. After DONE, start_req 0->1 -> cpu_rst=0 on the following clock.
- In RUN, raise init_req -> cpu_rst=1 and init_done=0 on the same clock; full 544-cycle sequence repeats; cpu_rst stays 1 until a new start_req edge.
- Toggle init_req and start_req repeatedly during the BHT phase -> no restart, no early release; bht_addr keeps counting monotonically to 255.
- Assert rst at BTB idx 100 -> all outputs zero and cpu_rst=1 next cycle; a new init_req edge restarts at btb_addr=0.
